window_gen: RTL
===============

WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 Parameter K_SIZE, default nn_pkg::K_SIZE (3): window edge length.
REQ-002 Parameter IMG_W, default nn_pkg::IMG_W (28): pixels per image row.
REQ-003 Parameter IMG_H, default nn_pkg::IMG_H (28): rows per frame.
REQ-004 Parameter PIX_W, default nn_pkg::PIX_W (9): signed pixel width.
REQ-005 Clocking is one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1: rising-edge clock.
REQ-007 Port rst, input, 1: asynchronous active-low reset.
REQ-008 Port pix_in, input, signed PIX_W: raster-order pixel.
REQ-009 Port pix_valid, input, 1: pix_in is valid.
REQ-010 Port pix_ready, output, 1: block accepts pix_in this cycle.
REQ-011 Port windowImg, output, signed PIX_W, array [0:K_SIZE-1][0:K_SIZE-1]: window feeding nn_block.
REQ-012 Port win_valid, output, 1: windowImg holds a complete window.
REQ-013 Port win_ready, input, 1: downstream consumes the window.
REQ-014 Port win_row / win_col, output, $clog2(IMG_H) / $clog2(IMG_W): top-left coordinate of the presented window.
REQ-015 Port frame_done, output, 1: one-cycle pulse after the last window of a frame is consumed.

Function
REQ-016 A pixel is accepted only when pix_valid && pix_ready are both high on a rising clk edge.
REQ-017 pix_ready SHALL equal !win_valid || win_ready, and SHALL be 0 during reset.
REQ-018 Column counter col runs 0..IMG_W-1 and row counter row runs 0..IMG_H-1, incrementing per accepted pixel. col wraps to 0 and increments row. At row=IMG_H-1, col=IMG_W-1 both counters wrap to 0, which starts a new frame.
REQ-019 The block keeps K_SIZE-1 line buffers of IMG_W pixels each. Each accepted pixel is pushed into the newest line; the pixel displaced from each line feeds the next-older line.
REQ-020 windowImg[r][c] SHALL equal pixel (row-K_SIZE+1+r, col-K_SIZE+1+c) of the most recent window: [0][0] is oldest/top-left, [K_SIZE-1][K_SIZE-1] is the newest accepted pixel.
REQ-021 Only valid-region windows are produced: a window exists iff the accepted pixel has row>=K_SIZE-1 and col>=K_SIZE-1. Each frame yields (IMG_H-K_SIZE+1)*(IMG_W-K_SIZE+1) windows.
REQ-022 Latency: win_valid rises on the edge that accepts the completing pixel, so the window is visible the following cycle.
REQ-023 Windows that straddle a row boundary (col<K_SIZE-1) SHALL never assert win_valid.
REQ-024 While win_valid=1 and win_ready=0, windowImg, win_row, win_col and win_valid SHALL hold stable.
REQ-025 When win_valid=1, win_ready=1 and a new completing pixel is accepted in the same cycle, the new window replaces the old one with no bubble.
REQ-026 FSM states: FILL, RUN and FLUSH.
- FILL: row<K_SIZE-1. No windows are produced.
- RUN: windows are produced.
- FLUSH: the last window of the frame is held until consumed, then frame_done pulses and the FSM returns to FILL. pix_ready=0 in FLUSH.
REQ-027 Pixel values pass through unmodified; no arithmetic or saturation is applied.

Reset
REQ-028 On rst=0, asynchronously: win_valid=0, frame_done=0, pix_ready=0, win_row=0, win_col=0, windowImg all 0, counters 0, FSM=FILL.
REQ-029 Line-buffer contents need not be cleared. Stale data SHALL never reach a valid window, because FILL refills them.
REQ-030 Reset asserted mid-frame discards the partial frame. The first pixel accepted after release is treated as (0,0).

Structure
REQ-031 IMG_W, IMG_H and PIX_W constants, plus the FSM state typedef, SHALL live in nn_pkg.
REQ-032 Each row delay SHALL be a sub-module line_buffer (parameters DEPTH=IMG_W, W=PIX_W) built as a circular register/RAM with a single pointer. window_gen instantiates K_SIZE-1 copies.

Verification
REQ-033 K=3, IMG 5x5, pixels 0..24, win_ready=1 -> the first window appears after pixel 12, equals {0,1,2;5,6,7;10,11,12} with (row,col)=(0,0), and 9 windows are produced in total.
REQ-034 Same stream -> no window after pixels 15 or 16 (row-straddle). The window after pixel 17 is {6,7,8;11,12,13;16,17,18} is wrong; the required value is {5,6,7;10,11,12;15,16,17} at (1,0).
REQ-035 win_ready=0 for 4 cycles on the first window -> pix_ready=0, outputs stable, then streaming resumes and all 9 windows arrive in order.
REQ-036 Pixel values -256 and 255 -> they appear bit-exact in windowImg.
REQ-037 rst pulsed low after pixel 8 -> all outputs 0. A fresh 0..24 frame then reproduces the REQ-033 results exactly.
REQ-038 Two back-to-back frames -> frame_done pulses exactly once per frame, in the cycle after the 9th window is consumed.

Source files
------------

// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Shared image/window geometry and the window_gen FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

  localparam int K_SIZE = 3;   // window edge length
  localparam int IMG_W  = 28;  // pixels per row
  localparam int IMG_H  = 28;  // rows per frame
  localparam int PIX_W  = 9;   // signed pixel width

  // window_gen sequencing states
  typedef logic [1:0] win_state_t;

  localparam win_state_t c_FILL  = 2'd0;  // priming the line buffers, no windows
  localparam win_state_t c_RUN   = 2'd1;  // valid-region windows are produced
  localparam win_state_t c_FLUSH = 2'd2;  // holding the final window of a frame

endpackage : nn_pkg
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer
//  Description : Fixed DEPTH-sample delay line built as a circular buffer
//                addressed by a single pointer. o_dout is the sample pushed
//                DEPTH pushes ago and is valid before the current push.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
  parameter int DEPTH = nn_pkg::IMG_W,
  parameter int W     = nn_pkg::PIX_W
) (
  input  logic                clk,
  input  logic                rst,     // asynchronous, active-low
  input  logic                i_push,
  input  logic signed [W-1:0] i_din,
  output logic signed [W-1:0] o_dout
);

  localparam int                 c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PTR_W-1:0] c_PTR_MAX = c_PTR_W'(DEPTH - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  logic signed [W-1:0]  r_mem [0:DEPTH-1];
  logic [c_PTR_W-1:0]   r_ptr;

  // The slot about to be overwritten holds the oldest sample: read-before-write.
  assign o_dout = r_mem[r_ptr];

  // Advance the single read/write pointer once per push, wrapping at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_push) begin
      r_ptr <= (r_ptr == c_PTR_MAX) ? '0 : r_ptr + c_PTR_ONE;
    end
  end

  // Storage is deliberately not reset; the FILL phase overwrites stale rows.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_ptr] <= i_din;
    end
  end

endmodule : line_buffer
`default_nettype wire

// File: rtl/window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : window_gen
//  Description : Raster-order sliding-window generator. Produces every
//                valid-region K_SIZE x K_SIZE window of an IMG_W x IMG_H frame
//                with a valid/ready handshake on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module window_gen #(
  parameter int K_SIZE = nn_pkg::K_SIZE,
  parameter int IMG_W  = nn_pkg::IMG_W,
  parameter int IMG_H  = nn_pkg::IMG_H,
  parameter int PIX_W  = nn_pkg::PIX_W
) (
  input  logic                        clk,
  input  logic                        rst,        // asynchronous, active-low
  input  logic signed [PIX_W-1:0]     pix_in,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  output logic signed [PIX_W-1:0]     windowImg [0:K_SIZE-1][0:K_SIZE-1],
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic [$clog2(IMG_H)-1:0]    win_row,
  output logic [$clog2(IMG_W)-1:0]    win_col,
  output logic                        frame_done
);

  import nn_pkg::*;

  localparam int c_ROW_W = $clog2(IMG_H);
  localparam int c_COL_W = $clog2(IMG_W);
  localparam int c_NLB   = K_SIZE - 1;

  localparam logic [c_ROW_W-1:0] c_ROW_MAX   = c_ROW_W'(IMG_H - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_FIRST = c_ROW_W'(K_SIZE - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_PRIME = c_ROW_W'(K_SIZE - 2);
  localparam logic [c_ROW_W-1:0] c_ROW_ONE   = c_ROW_W'(1);
  localparam logic [c_COL_W-1:0] c_COL_MAX   = c_COL_W'(IMG_W - 1);
  localparam logic [c_COL_W-1:0] c_COL_FIRST = c_COL_W'(K_SIZE - 1);
  localparam logic [c_COL_W-1:0] c_COL_ONE   = c_COL_W'(1);

  win_state_t                 r_state;
  logic [c_ROW_W-1:0]         r_row;
  logic [c_COL_W-1:0]         r_col;
  logic signed [PIX_W-1:0]    r_win [0:K_SIZE-1][0:K_SIZE-1];
  logic                       r_win_valid;
  logic [c_ROW_W-1:0]         r_win_row;
  logic [c_COL_W-1:0]         r_win_col;
  logic                       r_frame_done;

  logic                       w_accept;
  logic                       w_complete;
  logic                       w_last_col;
  logic                       w_last_row;
  logic signed [PIX_W-1:0]    w_lb_in  [0:c_NLB-1];
  logic signed [PIX_W-1:0]    w_lb_out [0:c_NLB-1];
  logic signed [PIX_W-1:0]    w_col_new [0:K_SIZE-1];

  // Upstream may only push when the output slot is free or being drained,
  // never while the last window of a frame is parked, and never in reset.
  assign pix_ready  = rst && (r_state != c_FLUSH) && (!r_win_valid || win_ready);
  assign w_accept   = pix_valid && pix_ready;
  assign w_last_col = (r_col == c_COL_MAX);
  assign w_last_row = (r_row == c_ROW_MAX);
  // The pixel at (row, col) closes a window only when the window lies fully
  // inside the current frame rows and does not wrap across a row boundary.
  assign w_complete = (r_row >= c_ROW_FIRST) && (r_col >= c_COL_FIRST);

  assign windowImg  = r_win;
  assign win_valid  = r_win_valid;
  assign win_row    = r_win_row;
  assign win_col    = r_win_col;
  assign frame_done = r_frame_done;

  // Line buffer 0 holds the previous row; each older buffer is fed by the
  // sample displaced from the one before it.
  for (genvar gi = 0; gi < c_NLB; gi++) begin : g_lb
    if (gi == 0) begin : g_head
      assign w_lb_in[gi] = pix_in;
    end else begin : g_tail
      assign w_lb_in[gi] = w_lb_out[gi-1];
    end

    line_buffer #(
      .DEPTH (IMG_W),
      .W     (PIX_W)
    ) u_line_buffer (
      .clk    (clk),
      .rst    (rst),
      .i_push (w_accept),
      .i_din  (w_lb_in[gi]),
      .o_dout (w_lb_out[gi])
    );
  end

  // Assemble the incoming right-hand column, oldest row at index 0.
  always_comb begin
    for (int r = 0; r < K_SIZE - 1; r++) begin
      w_col_new[r] = w_lb_out[K_SIZE-2-r];
    end
    w_col_new[K_SIZE-1] = pix_in;
  end

  // Track the raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + c_ROW_ONE;
      end else begin
        r_col <= r_col + c_COL_ONE;
      end
    end
  end

  // Slide the window one column left per accepted pixel; only accepted
  // pixels move it, so a stalled window is naturally held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < K_SIZE; r++) begin
        for (int c = 0; c < K_SIZE; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int r = 0; r < K_SIZE; r++) begin
        for (int c = 0; c < K_SIZE - 1; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
        r_win[r][K_SIZE-1] <= w_col_new[r];
      end
    end
  end

  // Output handshake: a completing pixel (re)loads the slot, a consumed
  // window without a replacement empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else if (w_accept && w_complete) begin
      r_win_valid <= 1'b1;
      r_win_row   <= r_row - c_ROW_FIRST;
      r_win_col   <= r_col - c_COL_FIRST;
    end else if (win_ready) begin
      r_win_valid <= 1'b0;
    end
  end

  // Frame sequencing: prime the buffers, stream windows, then park the
  // final window until it is taken and flag the end of the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= c_FILL;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        c_FILL: begin
          if (w_accept && w_last_col && (r_row == c_ROW_PRIME)) begin
            r_state <= c_RUN;
          end
        end
        c_RUN: begin
          if (w_accept && w_last_col && w_last_row) begin
            r_state <= c_FLUSH;
          end
        end
        c_FLUSH: begin
          if (win_ready) begin
            r_state      <= c_FILL;
            r_frame_done <= 1'b1;
          end
        end
        default: begin
          r_state <= c_FILL;
        end
      endcase
    end
  end

endmodule : window_gen
`default_nettype wire
